// File: rtl/tx_num_counter.sv
// Transmit word/length sequencer: walks the 64-bit words of an outgoing frame, pads short frames,
// flags the last payload/wire word and requests FCS insertion. Optional padding: define TX_PAD_EN.
module tx_num_counter #(
    parameter int WIDTH           = 13,
    parameter int MIN_FRAME_BYTES = 60,
    parameter int MAX_FRAME_BYTES = 9600
) (
    input  logic             txclk,
    input  logic             reset,
    input  logic             start_frame,
    input  logic [15:0]      frame_len,
    input  logic             data_advance,
    output logic             busy,
    output logic             data_phase,
    output logic             pad_phase,
    output logic             fcs_req,
    output logic             last_data,
    output logic             end_frame,
    output logic [7:0]       data_mask,
    output logic [7:0]       wire_mask,
    output logic [WIDTH-1:0] word_cnt,
    output logic             len_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
`ifdef TX_PAD_EN
        PAD  = 2'd2,
`endif
        FCS  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] word_cnt_q, word_cnt_d;
    logic [WIDTH-1:0] dw_q, dw_d;
    logic [WIDTH-1:0] tw_q, tw_d;
    logic [2:0]       len_lo_q, len_lo_d;
    logic [2:0]       tb_lo_q, tb_lo_d;
    logic             len_err_q, len_err_d;

    logic             len_ok;
    logic [15:0]      tb_calc;
    logic [WIDTH-1:0] dw_calc;
    logic [WIDTH-1:0] tw_calc;

    assign len_ok = (frame_len != 16'd0) && (frame_len <= 16'(MAX_FRAME_BYTES));
`ifdef TX_PAD_EN
    assign tb_calc = (frame_len < 16'(MIN_FRAME_BYTES)) ? 16'(MIN_FRAME_BYTES) : frame_len;
`else
    assign tb_calc = frame_len;
`endif
    // ceil(bytes/8) without a wide adder: whole words plus one if any bytes remain
    assign dw_calc = WIDTH'(frame_len[15:3]) + WIDTH'(|frame_len[2:0]);
    assign tw_calc = WIDTH'(tb_calc[15:3]) + WIDTH'(|tb_calc[2:0]);

    always_ff @(posedge txclk) begin
        if (reset) begin
            state_q    <= IDLE;
            word_cnt_q <= '0;
            dw_q       <= '0;
            tw_q       <= '0;
            len_lo_q   <= '0;
            tb_lo_q    <= '0;
            len_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            dw_q       <= dw_d;
            tw_q       <= tw_d;
            len_lo_q   <= len_lo_d;
            tb_lo_q    <= tb_lo_d;
            len_err_q  <= len_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        dw_d       = dw_q;
        tw_d       = tw_q;
        len_lo_d   = len_lo_q;
        tb_lo_d    = tb_lo_q;
        len_err_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_frame) begin
                    if (len_ok) begin
                        state_d    = DATA;
                        word_cnt_d = '0;
                        dw_d       = dw_calc;
                        tw_d       = tw_calc;
                        len_lo_d   = frame_len[2:0];
                        tb_lo_d    = tb_calc[2:0];
                    end else begin
                        len_err_d = 1'b1;
                    end
                end
            end
            DATA: begin
                if (data_advance) begin
                    if (word_cnt_q == dw_q - WIDTH'(1)) begin
`ifdef TX_PAD_EN
                        if (tw_q > dw_q) begin
                            state_d    = PAD;
                            word_cnt_d = word_cnt_q + WIDTH'(1);
                        end else begin
                            state_d = FCS;
                        end
`else
                        state_d = FCS;
`endif
                    end else begin
                        word_cnt_d = word_cnt_q + WIDTH'(1);
                    end
                end
            end
`ifdef TX_PAD_EN
            PAD: begin
                if (data_advance) begin
                    if (word_cnt_q == tw_q - WIDTH'(1)) begin
                        state_d = FCS;
                    end else begin
                        word_cnt_d = word_cnt_q + WIDTH'(1);
                    end
                end
            end
`endif
            FCS: begin
                if (data_advance) begin
                    state_d    = IDLE;
                    word_cnt_d = '0;
                end
            end
            default: begin
                state_d    = IDLE;
                word_cnt_d = '0;
            end
        endcase
    end

    logic       on_wire;
    logic [7:0] data_lane_hit;
    logic [7:0] wire_lane_hit;

    assign busy       = (state_q != IDLE);
    assign data_phase = (state_q == DATA);
    assign fcs_req    = (state_q == FCS);
`ifdef TX_PAD_EN
    assign pad_phase  = (state_q == PAD);
`else
    assign pad_phase  = 1'b0;
`endif
    assign on_wire    = data_phase | pad_phase;
    assign last_data  = data_phase && (word_cnt_q == dw_q - WIDTH'(1));
    assign end_frame  = on_wire && (word_cnt_q == tw_q - WIDTH'(1));
    assign word_cnt   = word_cnt_q;
    assign len_err    = len_err_q;

    // a zero remainder means the final word is completely filled
    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
        assign data_lane_hit[gi] = (len_lo_q == 3'd0) || (3'(gi) < len_lo_q);
        assign wire_lane_hit[gi] = (tb_lo_q == 3'd0) || (3'(gi) < tb_lo_q);
    end

    assign data_mask = !data_phase ? 8'h00 : (last_data ? data_lane_hit : 8'hFF);
    assign wire_mask = !on_wire    ? 8'h00 : (end_frame ? wire_lane_hit : 8'hFF);

endmodule

// File: tb/tb_tx_num_counter.sv
// Scoreboard bench for tx_num_counter: expected per-word output records are queued when a frame
// is started and compared each cycle the DUT presents a word or FCS slot.
module tb_tx_num_counter;

    logic        txclk = 1'b0;
    logic        reset = 1'b1;
    logic        start_frame = 1'b0;
    logic [15:0] frame_len = 16'd0;
    logic        data_advance = 1'b0;
    logic        busy, data_phase, pad_phase, fcs_req, last_data, end_frame, len_err;
    logic [7:0]  data_mask, wire_mask;
    logic [12:0] word_cnt;

    int total = 0;
    int bad   = 0;

    logic [35:0] exp_q[$];
    logic [35:0] obs;

    tx_num_counter dut (
        .txclk       (txclk),
        .reset       (reset),
        .start_frame (start_frame),
        .frame_len   (frame_len),
        .data_advance(data_advance),
        .busy        (busy),
        .data_phase  (data_phase),
        .pad_phase   (pad_phase),
        .fcs_req     (fcs_req),
        .last_data   (last_data),
        .end_frame   (end_frame),
        .data_mask   (data_mask),
        .wire_mask   (wire_mask),
        .word_cnt    (word_cnt),
        .len_err     (len_err)
    );

    always #5 txclk = ~txclk;

    // {len_err, busy, data_phase, pad_phase, fcs_req, last_data, end_frame, data_mask, wire_mask, word_cnt}
    assign obs = {len_err, busy, data_phase, pad_phase, fcs_req, last_data, end_frame,
                  data_mask, wire_mask, word_cnt};

    function automatic logic [7:0] lanes(input int n);
        logic [7:0] ff;
        ff = 8'hFF;
        if (n == 0) return ff;
        return ff >> (8 - n);
    endfunction

    function automatic int padded_len(input int len);
`ifdef TX_PAD_EN
        return (len < 60) ? 60 : len;
`else
        return len;
`endif
    endfunction

    task automatic push_frame(input int len);
        int dw, tb, tw;
        logic [7:0] dm, wm;
        dw = (len + 7) / 8;
        tb = padded_len(len);
        tw = (tb + 7) / 8;
        for (int w = 0; w < tw; w++) begin
            dm = (w < dw) ? ((w == dw - 1) ? lanes(len % 8) : 8'hFF) : 8'h00;
            wm = (w == tw - 1) ? lanes(tb % 8) : 8'hFF;
            exp_q.push_back({1'b0, 1'b1, (w < dw), (w >= dw), 1'b0, (w == dw - 1), (w == tw - 1),
                             dm, wm, 13'(w)});
        end
        exp_q.push_back({1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 13'(tw - 1)});
    endtask

    // Runs one frame; optionally stalls at a word and pokes a (to be ignored) start while busy.
    task automatic run_frame(input int len, input int stall_at, input int stall_n, input int poke_at);
        logic [35:0] exp;
        int stall_left, guard, nwords;
        bit poked;
        exp_q.delete();
        push_frame(len);
        nwords = exp_q.size();
        @(negedge txclk);
        start_frame = 1'b1;
        frame_len = 16'(len);
        data_advance = 1'b0;
        @(negedge txclk);
        start_frame = 1'b0;
        stall_left = stall_n;
        guard = 0;
        poked = 1'b0;
        while (exp_q.size() > 0 && guard < 20000) begin
            exp = exp_q[0];
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL frame len=%0d word: got %h expected %h", len, obs, exp);
            end
            start_frame = 1'b0;
            if (!poked && poke_at >= 0 && exp[12:0] == 13'(poke_at) && !exp[31]) begin
                start_frame = 1'b1;
                frame_len = 16'd0;
                poked = 1'b1;
            end
            if (stall_left > 0 && exp[12:0] == 13'(stall_at) && !exp[31]) begin
                data_advance = 1'b0;
                stall_left--;
            end else begin
                data_advance = 1'b1;
                void'(exp_q.pop_front());
            end
            @(negedge txclk);
            guard++;
        end
        data_advance = 1'b0;
        start_frame = 1'b0;
        total++;
        if (guard >= 20000) begin
            bad++;
            $display("FAIL frame len=%0d timeout: got %0d cycles required < 20000", len, guard);
        end else if (obs !== 36'h0) begin
            bad++;
            $display("FAIL frame len=%0d idle after: got %h expected 0", len, obs);
        end
        $display("frame len=%0d words+fcs=%0d stall=%0d poke=%0d done", len, nwords, stall_n, poke_at);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start_frame = 1'b1;
        frame_len = 16'd64;
        repeat (3) @(negedge txclk);
        total++;
        if (obs !== 36'h0) begin
            bad++;
            $display("FAIL reset state: got %h expected 0", obs);
        end
        start_frame = 1'b0;
        reset = 1'b0;
        @(negedge txclk);
        total++;
        if (obs !== 36'h0) begin
            bad++;
            $display("FAIL after reset release: got %h expected 0", obs);
        end
        $display("reset check done");
    endtask

    task automatic test_frames;
        int lens[9] = '{64, 61, 20, 1, 8, 57, 59, 60, 9600};
        foreach (lens[i]) run_frame(lens[i], -1, 0, -1);
    endtask

    task automatic test_stall;
        run_frame(100, 5, 3, -1);
    endtask

    task automatic test_busy_ignore;
        run_frame(64, -1, 0, 2);
        run_frame(20, 1, 2, 1);
    endtask

    task automatic test_back_to_back;
        run_frame(61, -1, 0, -1);
        run_frame(20, -1, 0, -1);
    endtask

    task automatic test_len_err;
        int bad_lens[2] = '{0, 9601};
        foreach (bad_lens[i]) begin
            @(negedge txclk);
            start_frame = 1'b1;
            frame_len = 16'(bad_lens[i]);
            @(negedge txclk);
            start_frame = 1'b0;
            total++;
            if (obs !== {1'b1, 35'h0}) begin
                bad++;
                $display("FAIL len_err pulse len=%0d: got %h expected %h", bad_lens[i], obs, {1'b1, 35'h0});
            end
            @(negedge txclk);
            total++;
            if (obs !== 36'h0) begin
                bad++;
                $display("FAIL len_err clear len=%0d: got %h expected 0", bad_lens[i], obs);
            end
            $display("len_err len=%0d checked", bad_lens[i]);
        end
    endtask

    task automatic test_reset_mid;
        int len;
`ifdef TX_PAD_EN
        len = 20;
`else
        len = 40;
`endif
        @(negedge txclk);
        start_frame = 1'b1;
        frame_len = 16'(len);
        @(negedge txclk);
        start_frame = 1'b0;
        data_advance = 1'b1;
        repeat (4) @(negedge txclk);
        data_advance = 1'b0;
        total++;
        if (word_cnt !== 13'd4 || busy !== 1'b1) begin
            bad++;
            $display("FAIL pre-reset word: got cnt=%0d busy=%b expected cnt=4 busy=1", word_cnt, busy);
        end
        reset = 1'b1;
        data_advance = 1'b1;
        start_frame = 1'b1;
        frame_len = 16'd64;
        @(negedge txclk);
        reset = 1'b0;
        data_advance = 1'b0;
        start_frame = 1'b0;
        total++;
        if (obs !== 36'h0) begin
            bad++;
            $display("FAIL mid-frame reset: got %h expected 0", obs);
        end
        $display("mid-frame reset len=%0d checked", len);
        run_frame(64, -1, 0, -1);
    endtask

    initial begin
        test_reset;
        test_frames;
        test_stall;
        test_busy_ignore;
        test_back_to_back;
        test_len_err;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
